// File: rtl/rv32v_lane_mem_sequencer.sv
// Multi-lane vector memory sequencer: serialises active lanes onto a single
// 32-bit dcache port, aligns load data per element width, and returns the
// assembled lane results (or a misalignment exception) to the ROB.
module rv32v_lane_mem_sequencer #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_eew,
  input  logic [LANES-1:0]      req_lane_en,
  input  logic [LANES*32-1:0]   req_addr,
  input  logic [LANES*32-1:0]   req_wdata,
  input  logic [IDX_W-1:0]      req_index,
  output logic                  dmem_ren,
  output logic                  dmem_wen,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_store,
  output logic [3:0]            dmem_byte_en,
  input  logic [31:0]           dmem_load,
  input  logic                  dhit,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [LANES*32-1:0]   res_wdata,
  output logic [LANES-1:0]      res_lane_en,
  output logic [IDX_W-1:0]      res_index,
  output logic                  res_exception,
  output logic [LANE_W-1:0]     res_exc_lane
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_d;
  logic                  store_q, store_d;
  logic [1:0]            eew_q, eew_d;
  logic [LANES-1:0]      lane_en_q, lane_en_d;
  logic [LANES*32-1:0]   addr_q, addr_d;
  logic [LANES*32-1:0]   wdata_q, wdata_d;
  logic                  res_valid_d;
  logic [LANES*32-1:0]   res_wdata_d;
  logic [LANES-1:0]      res_lane_en_d;
  logic [IDX_W-1:0]      res_index_d;
  logic                  res_exception_d;
  logic [LANE_W-1:0]     res_exc_lane_d;

  logic [LANES-1:0]      pending;
  logic [LANES-1:0]      remaining;
  logic [LANE_W-1:0]     cur_lane;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic                  last_lane;
  logic                  misaligned;
  logic                  active;
  logic                  hit;
  logic [31:0]           load_elem;
  logic [31:0]           shifted_load;

  // Pick the lowest-numbered enabled lane that has not completed yet.
  always_comb begin
    pending   = lane_en_q & ~res_lane_en;
    cur_lane  = '0;
    cur_addr  = '0;
    cur_wdata = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        cur_lane  = LANE_W'(i);
        cur_addr  = addr_q[32*i +: 32];
        cur_wdata = wdata_q[32*i +: 32];
      end
    end
    remaining = pending & ~(LANES'(1) << cur_lane);
    last_lane = (remaining == '0);
  end

  // Alignment check and dcache port drive for the current lane.
  always_comb begin
    misaligned   = ((eew_q == 2'b01) && cur_addr[0]) ||
                   (eew_q[1] && (cur_addr[1:0] != 2'b00));
    active       = (state == ACCESS) && !misaligned && !flush;
    dmem_ren     = active && !store_q;
    dmem_wen     = active && store_q;
    hit          = dhit && active;
    dmem_addr    = active ? {cur_addr[31:2], 2'b00} : 32'h0;
    dmem_byte_en = 4'h0;
    dmem_store   = 32'h0;
    if (active) begin
      case (eew_q)
        2'b00: begin
          dmem_byte_en = 4'b0001 << cur_addr[1:0];
          dmem_store   = {4{cur_wdata[7:0]}};
        end
        2'b01: begin
          dmem_byte_en = cur_addr[1] ? 4'b1100 : 4'b0011;
          dmem_store   = {2{cur_wdata[15:0]}};
        end
        default: begin
          dmem_byte_en = 4'b1111;
          dmem_store   = cur_wdata;
        end
      endcase
    end
  end

  // Align the returned load word down to the element and zero-extend it.
  always_comb begin
    shifted_load = 32'h0;
    load_elem    = dmem_load;
    case (eew_q)
      2'b00: begin
        shifted_load = dmem_load >> {cur_addr[1:0], 3'b000};
        load_elem    = {24'h0, shifted_load[7:0]};
      end
      2'b01: begin
        shifted_load = dmem_load >> {cur_addr[1], 4'b0000};
        load_elem    = {16'h0, shifted_load[15:0]};
      end
      default: load_elem = dmem_load;
    endcase
  end

  assign req_ready = (state == IDLE);

  // Next-state and result-buffer update.
  always_comb begin
    state_d         = state;
    store_d         = store_q;
    eew_d           = eew_q;
    lane_en_d       = lane_en_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    res_wdata_d     = res_wdata;
    res_lane_en_d   = res_lane_en;
    res_index_d     = res_index;
    res_exception_d = res_exception;
    res_exc_lane_d  = res_exc_lane;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_d         = req_store;
            eew_d           = req_eew;
            lane_en_d       = req_lane_en;
            addr_d          = req_addr;
            wdata_d         = req_wdata;
            res_index_d     = req_index;
            res_wdata_d     = '0;
            res_lane_en_d   = '0;
            res_exception_d = 1'b0;
            res_exc_lane_d  = '0;
            state_d         = (req_lane_en != '0) ? ACCESS : RESP;
          end
        end
        ACCESS: begin
          if (misaligned) begin
            res_exception_d = 1'b1;
            res_exc_lane_d  = cur_lane;
            state_d         = RESP;
          end else if (hit) begin
            res_lane_en_d = res_lane_en | (LANES'(1) << cur_lane);
            if (!store_q) begin
              for (int i = 0; i < int'(LANES); i++) begin
                if (LANE_W'(i) == cur_lane) res_wdata_d[32*i +: 32] = load_elem;
              end
            end
            if (last_lane) state_d = RESP;
          end
        end
        RESP: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    res_valid_d = (state_d == RESP);
  end

  // State and latch registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      store_q       <= 1'b0;
      eew_q         <= 2'b00;
      lane_en_q     <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      res_valid     <= 1'b0;
      res_wdata     <= '0;
      res_lane_en   <= '0;
      res_index     <= '0;
      res_exception <= 1'b0;
      res_exc_lane  <= '0;
    end else begin
      state         <= state_d;
      store_q       <= store_d;
      eew_q         <= eew_d;
      lane_en_q     <= lane_en_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      res_valid     <= res_valid_d;
      res_wdata     <= res_wdata_d;
      res_lane_en   <= res_lane_en_d;
      res_index     <= res_index_d;
      res_exception <= res_exception_d;
      res_exc_lane  <= res_exc_lane_d;
    end
  end

endmodule

// File: tb/tb_rv32v_lane_mem_sequencer.sv
// Directed self-checking bench for rv32v_lane_mem_sequencer (LANES=2).
module tb_rv32v_lane_mem_sequencer;

  logic        CLK;
  logic        nRST;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_eew;
  logic [1:0]  req_lane_en;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_index;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_store;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_load;
  logic        dhit;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_wdata;
  logic [1:0]  res_lane_en;
  logic [4:0]  res_index;
  logic        res_exception;
  logic [0:0]  res_exc_lane;

  int checks;
  int errors;

  rv32v_lane_mem_sequencer #(.LANES(2), .IDX_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_eew(req_eew), .req_lane_en(req_lane_en), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_index(req_index),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_store(dmem_store), .dmem_byte_en(dmem_byte_en),
    .dmem_load(dmem_load), .dhit(dhit),
    .res_valid(res_valid), .res_ready(res_ready), .res_wdata(res_wdata),
    .res_lane_en(res_lane_en), .res_index(res_index),
    .res_exception(res_exception), .res_exc_lane(res_exc_lane)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count one comparison and report it if it mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one request at a negedge; returns at the first negedge after the accept edge.
  task automatic issue(input logic st, input logic [1:0] eew, input logic [1:0] en,
                       input logic [31:0] a1, input logic [31:0] a0,
                       input logic [31:0] w1, input logic [31:0] w0,
                       input logic [4:0] idx);
    check("req_ready_before_issue", 64'(req_ready), 64'd1);
    req_store   = st;
    req_eew     = eew;
    req_lane_en = en;
    req_addr    = {a1, a0};
    req_wdata   = {w1, w0};
    req_index   = idx;
    req_valid   = 1'b1;
    @(negedge CLK);
    req_valid   = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    nRST = 1'b0; flush = 1'b0; req_valid = 1'b0; req_store = 1'b0;
    req_eew = 2'b00; req_lane_en = 2'b00; req_addr = '0; req_wdata = '0;
    req_index = '0; dmem_load = '0; dhit = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_ren", 64'(dmem_ren), 64'd0);
    check("rst_res_wdata", res_wdata, 64'd0);
    check("rst_res_exc", 64'(res_exception), 64'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // Two-lane eew32 load, hit every cycle
    issue(1'b0, 2'b10, 2'b11, 32'h104, 32'h100, 32'h0, 32'h0, 5'd3);
    check("t1_ren_l0", 64'(dmem_ren), 64'd1);
    check("t1_addr_l0", 64'(dmem_addr), 64'h100);
    check("t1_be_l0", 64'(dmem_byte_en), 64'hF);
    check("t1_rv_c1", 64'(res_valid), 64'd0);
    dhit = 1'b1; dmem_load = 32'hAAAA0000;
    @(negedge CLK);
    check("t1_ren_l1", 64'(dmem_ren), 64'd1);
    check("t1_addr_l1", 64'(dmem_addr), 64'h104);
    check("t1_rv_c2", 64'(res_valid), 64'd0);
    dmem_load = 32'hBBBB1111;
    @(negedge CLK);
    dhit = 1'b0;
    check("t1_rv_c3", 64'(res_valid), 64'd1);
    check("t1_data", res_wdata, 64'hBBBB1111_AAAA0000);
    check("t1_lane_en", 64'(res_lane_en), 64'h3);
    check("t1_exc", 64'(res_exception), 64'd0);
    check("t1_index", 64'(res_index), 64'd3);
    check("t1_ren_resp", 64'(dmem_ren), 64'd0);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    check("t1_rv_drop", 64'(res_valid), 64'd0);

    // eew8 load from byte 3
    issue(1'b0, 2'b00, 2'b01, 32'h0, 32'h203, 32'h0, 32'h0, 5'd4);
    check("t2_be", 64'(dmem_byte_en), 64'h8);
    check("t2_addr", 64'(dmem_addr), 64'h200);
    dhit = 1'b1; dmem_load = 32'h12345678;
    @(negedge CLK);
    dhit = 1'b0;
    check("t2_rv", 64'(res_valid), 64'd1);
    check("t2_data", res_wdata, 64'h00000000_00000012);
    check("t2_lane_en", 64'(res_lane_en), 64'h1);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;

    // eew16 store on lane1 only
    issue(1'b1, 2'b01, 2'b10, 32'h302, 32'h0, 32'h0000BEEF, 32'h0, 5'd5);
    check("t3_wen", 64'(dmem_wen), 64'd1);
    check("t3_ren", 64'(dmem_ren), 64'd0);
    check("t3_addr", 64'(dmem_addr), 64'h300);
    check("t3_be", 64'(dmem_byte_en), 64'hC);
    check("t3_store", 64'(dmem_store), 64'hBEEFBEEF);
    dhit = 1'b1;
    @(negedge CLK);
    dhit = 1'b0;
    check("t3_rv", 64'(res_valid), 64'd1);
    check("t3_wen_once", 64'(dmem_wen), 64'd0);
    check("t3_data", res_wdata, 64'd0);
    check("t3_lane_en", 64'(res_lane_en), 64'h2);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;

    // Lane1 misaligned eew32 load
    issue(1'b0, 2'b10, 2'b11, 32'h102, 32'h100, 32'h0, 32'h0, 5'd6);
    check("t4_ren_l0", 64'(dmem_ren), 64'd1);
    dhit = 1'b1; dmem_load = 32'h11223344;
    @(negedge CLK);
    check("t4_ren_l1", 64'(dmem_ren), 64'd0);
    check("t4_wen_l1", 64'(dmem_wen), 64'd0);
    @(negedge CLK);
    dhit = 1'b0;
    check("t4_rv", 64'(res_valid), 64'd1);
    check("t4_exc", 64'(res_exception), 64'd1);
    check("t4_exc_lane", 64'(res_exc_lane), 64'd1);
    check("t4_lane_en", 64'(res_lane_en), 64'h1);
    check("t4_data", res_wdata, 64'h00000000_11223344);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;

    // Dcache stall then ROB backpressure
    issue(1'b0, 2'b10, 2'b01, 32'h0, 32'h400, 32'h0, 32'h0, 5'd7);
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_ren", 64'(dmem_ren), 64'd1);
      check("t5_stall_addr", 64'(dmem_addr), 64'h400);
      check("t5_stall_rdy", 64'(req_ready), 64'd0);
      check("t5_stall_rv", 64'(res_valid), 64'd0);
      @(negedge CLK);
    end
    dhit = 1'b1; dmem_load = 32'hCAFEF00D;
    @(negedge CLK);
    dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_rv", 64'(res_valid), 64'd1);
      check("t5_hold_data", res_wdata, 64'h00000000_CAFEF00D);
      check("t5_hold_idx", 64'(res_index), 64'd7);
      check("t5_hold_rdy", 64'(req_ready), 64'd0);
      @(negedge CLK);
    end
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    check("t5_rv_drop", 64'(res_valid), 64'd0);
    check("t5_rdy_back", 64'(req_ready), 64'd1);

    // Flush during lane1 access
    issue(1'b0, 2'b10, 2'b11, 32'h504, 32'h500, 32'h0, 32'h0, 5'd8);
    dhit = 1'b1; dmem_load = 32'h55555555;
    @(negedge CLK);
    check("t6_ren_l1", 64'(dmem_ren), 64'd1);
    check("t6_addr_l1", 64'(dmem_addr), 64'h504);
    flush = 1'b1;
    #1;
    check("t6_ren_flushed", 64'(dmem_ren), 64'd0);
    @(negedge CLK);
    dhit = 1'b0;
    check("t6_idle_rdy", 64'(req_ready), 64'd1);
    check("t6_no_rv", 64'(res_valid), 64'd0);
    // Request offered together with flush must be dropped
    req_lane_en = 2'b00; req_index = 5'd9; req_valid = 1'b1;
    @(negedge CLK);
    check("t6_flush_req_rdy", 64'(req_ready), 64'd1);
    check("t6_flush_req_rv", 64'(res_valid), 64'd0);
    flush = 1'b0; req_valid = 1'b0;
    // Empty-mask request goes straight to a response
    issue(1'b0, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd10);
    check("t6_empty_rv", 64'(res_valid), 64'd1);
    check("t6_empty_lane_en", 64'(res_lane_en), 64'd0);
    check("t6_empty_exc", 64'(res_exception), 64'd0);
    check("t6_empty_idx", 64'(res_index), 64'd10);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    check("t6_end_rv", 64'(res_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
